// File: rtl/game_pkg.sv
// game_pkg: shared definitions for the game controller slice.
//   state_t  : game state encoding (00 IDLE, 01 RUN, 10 DEAD, 11 PAUSED)
//   BCD_W    : width of one BCD score digit
//   BCD_NINE : the all-9s value of one digit, used for carry and saturation
package game_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_DEAD   = 2'b10,
    ST_PAUSED = 2'b11
  } state_t;

endpackage

// File: rtl/game_controller_if.sv
// game_controller_if: bundles the game controller's per-frame inputs and its
// state/speed/score outputs.
//   master : drives frame_tick, score_tick, jump, pause, pixel_valid, dino_px,
//            obstacle_px; observes game_state, dx, score, hiscore, new_hi
//   slave  : the controller side (mirror of master)
interface game_controller_if
  import game_pkg::*;
#(
  parameter int DIGITS = 5,
  parameter int DX_W   = 4
);

  logic                      frame_tick;
  logic                      score_tick;
  logic                      jump;
  logic                      pause;
  logic                      pixel_valid;
  logic                      dino_px;
  logic                      obstacle_px;
  logic [1:0]                game_state;
  logic [DX_W-1:0]           dx;
  logic [BCD_W*DIGITS-1:0]   score;
  logic [BCD_W*DIGITS-1:0]   hiscore;
  logic                      new_hi;

  modport master (
    output frame_tick, score_tick, jump, pause, pixel_valid, dino_px, obstacle_px,
    input  game_state, dx, score, hiscore, new_hi
  );

  modport slave (
    input  frame_tick, score_tick, jump, pause, pixel_valid, dino_px, obstacle_px,
    output game_state, dx, score, hiscore, new_hi
  );

endinterface

// File: rtl/bcd_counter.sv
// bcd_counter: saturating multi-digit BCD up-counter with ripple carry.
//   clk   : clock, posedge
//   rst   : synchronous active-high reset, value -> 0
//   clr   : synchronous clear, value -> 0 (priority over inc)
//   inc   : add one; ignored once all digits are 9
//   value : BCD value, digit 0 in the LSBs
//   sat   : all digits are 9
module bcd_counter
  import game_pkg::*;
#(
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [BCD_W*DIGITS-1:0] value,
  output logic                    sat
);

  logic [BCD_W*DIGITS-1:0] valueNxt;
  logic                    carry;

  always_comb begin
    sat = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (value[i*BCD_W +: BCD_W] != BCD_NINE) sat = 1'b0;
    end
  end

  // Carry enters digit 0 and ripples up while digits roll over from 9.
  always_comb begin
    valueNxt = value;
    carry    = inc & ~sat;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[i*BCD_W +: BCD_W] == BCD_NINE) begin
          valueNxt[i*BCD_W +: BCD_W] = '0;
        end else begin
          valueNxt[i*BCD_W +: BCD_W] = value[i*BCD_W +: BCD_W] + 1'b1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) value <= '0;
    else            value <= valueNxt;
  end

endmodule

// File: rtl/game_controller.sv
// game_controller: game state machine with collision detection, BCD score,
// high score and obstacle speed ramp.
//   clk  : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : game_controller_if.slave
//          in : frame_tick, score_tick, jump, pause, pixel_valid, dino_px, obstacle_px
//          out: game_state, dx, score, hiscore, new_hi (all registered)
// Build option: define GAME_PAUSE_EN to enable the PAUSED state driven by
// pause rising edges; otherwise the pause input is ignored.
module game_controller
  import game_pkg::*;
#(
  parameter int DIGITS           = 5,
  parameter int DX_W             = 4,
  parameter int DX_INIT          = 5,
  parameter int DX_MAX           = 12,
  parameter int RAMP_POINTS      = 100,
  parameter int DEAD_HOLD_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  game_controller_if.slave   bus
);

  localparam int RAMP_W = (RAMP_POINTS > 1) ? $clog2(RAMP_POINTS) : 1;
  localparam int HOLD_W = (DEAD_HOLD_FRAMES > 0) ? $clog2(DEAD_HOLD_FRAMES + 1) : 1;

  state_t                  state, stateNxt;
  logic                    jumpQ;
  logic                    jumpRise;
  logic                    pauseRise;
  logic                    hitNow;
  logic                    hitLatch;
  logic [RAMP_W-1:0]       rampCnt;
  logic [HOLD_W-1:0]       holdCnt;
  logic                    holdDone;
  logic [DX_W-1:0]         dx;
  logic [BCD_W*DIGITS-1:0] scoreVal;
  logic [BCD_W*DIGITS-1:0] hiscore;
  logic                    newHi;
  logic                    scoreSat;
  logic                    goRun;
  logic                    goDead;
  logic                    goPause;
  logic                    scoreInc;

  assign jumpRise = bus.jump & ~jumpQ;
  assign hitNow   = bus.pixel_valid & bus.dino_px & bus.obstacle_px;
  assign holdDone = (holdCnt >= HOLD_W'(DEAD_HOLD_FRAMES));

`ifdef GAME_PAUSE_EN
  logic pauseQ;

  always_ff @(posedge clk) begin
    if (rst) pauseQ <= 1'b0;
    else     pauseQ <= bus.pause;
  end

  assign pauseRise = bus.pause & ~pauseQ;
`else
  logic unusedPause;
  assign unusedPause = bus.pause;
  assign pauseRise   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    goRun    = 1'b0;
    goDead   = 1'b0;
    goPause  = 1'b0;
    scoreInc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (jumpRise) begin
          stateNxt = ST_RUN;
          goRun    = 1'b1;
        end
      end
      ST_RUN: begin
        // Collision death outranks a simultaneous pause request.
        if (bus.frame_tick && (hitLatch || hitNow)) begin
          stateNxt = ST_DEAD;
          goDead   = 1'b1;
        end else if (pauseRise) begin
          stateNxt = ST_PAUSED;
          goPause  = 1'b1;
        end
        // Score only advances on cycles that stay in RUN, so a tick
        // coinciding with death or pause entry is dropped.
        scoreInc = bus.score_tick & ~scoreSat & ~goDead & ~goPause;
      end
      ST_DEAD: begin
        if (jumpRise && holdDone) stateNxt = ST_IDLE;
      end
`ifdef GAME_PAUSE_EN
      ST_PAUSED: begin
        if (pauseRise) stateNxt = ST_RUN;
      end
`endif
      default: stateNxt = ST_IDLE;
    endcase
  end

  bcd_counter #(
    .DIGITS (DIGITS)
  ) u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (goRun),
    .inc   (scoreInc),
    .value (scoreVal),
    .sat   (scoreSat)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      jumpQ    <= 1'b0;
      hitLatch <= 1'b0;
      rampCnt  <= '0;
      holdCnt  <= '0;
      dx       <= DX_W'(DX_INIT);
      hiscore  <= '0;
      newHi    <= 1'b0;
    end else begin
      jumpQ <= bus.jump;

      if (goRun) begin
        dx       <= DX_W'(DX_INIT);
        rampCnt  <= '0;
        newHi    <= 1'b0;
        hitLatch <= 1'b0;
      end

      if (state == ST_RUN) begin
        if (bus.frame_tick || goPause) hitLatch <= 1'b0;
        else if (hitNow)               hitLatch <= 1'b1;
      end

      // One speed step per RAMP_POINTS score increments.
      if (scoreInc) begin
        if (rampCnt == RAMP_W'(RAMP_POINTS - 1)) begin
          rampCnt <= '0;
          if (dx < DX_W'(DX_MAX)) dx <= dx + 1'b1;
        end else begin
          rampCnt <= rampCnt + 1'b1;
        end
      end

      // BCD digit order makes a plain unsigned compare valid.
      if (goDead) begin
        holdCnt <= '0;
        if (scoreVal > hiscore) begin
          hiscore <= scoreVal;
          newHi   <= 1'b1;
        end
      end

      if (state == ST_DEAD && bus.frame_tick && !holdDone) holdCnt <= holdCnt + 1'b1;
    end
  end

  assign bus.game_state = state;
  assign bus.dx         = dx;
  assign bus.score      = scoreVal;
  assign bus.hiscore    = hiscore;
  assign bus.new_hi     = newHi;

endmodule
